interfaz_adc_spi: RTL
=====================

INTERFAZ_ADC_SPI -- requirements
Module: interfaz_adc_spi

Interface
REQ-001 Parameter N, default 25: width of sample word Uk.
REQ-002 Parameter F, default 16: fractional bits of Uk, signed two's complement; F SHALL be at least 11 and at most N-2.
REQ-003 Parameter SCLK_DIV, default 4: Clk cycles per SCLK half-period; minimum 1.
REQ-004 Parameter SAMPLE_DIV, default 5000: Clk cycles per sample period; SHALL exceed 32*SCLK_DIV+3.
REQ-005 Clk  input  1  system clock; all logic on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 SDATA  input  1  serial data from 12-bit ADC, MSB first.
REQ-008 CS_n  output  1  ADC chip select, active-low.
REQ-009 SCLK  output  1  ADC serial clock, idles high.
REQ-010 Uk  output  N  latest sample, signed fixed point, F fractional bits; feeds the 200 Hz low-pass filter input.
REQ-011 Bandera_ADC  output  1  one-Clk pulse, new Uk valid; feeds the filter start flag.
REQ-012 Overrun  output  1  sticky flag, sample tick lost during a frame.

Function
REQ-013 A free-running counter SHALL count 0..SAMPLE_DIV-1 and wrap; the cycle it holds SAMPLE_DIV-1 is the sample tick.
REQ-014 FSM states: IDLE, SETUP, SHIFT, DONE.
REQ-015 IDLE: CS_n=1, SCLK=1; on sample tick go to SETUP next cycle.
REQ-016 SETUP: CS_n=0 for exactly 1 Clk, SCLK=1; then SHIFT.
REQ-017 SHIFT: CS_n=0; SCLK toggles every SCLK_DIV Clk cycles, first toggle high-to-low, 16 full SCLK periods (32*SCLK_DIV Clk cycles).
REQ-018 SDATA SHALL be captured into a 16-bit shift register in the Clk cycle where SCLK goes low-to-high; 16 captures per frame.
REQ-019 After the 16th rising SCLK edge, FSM enters DONE, CS_n=1, SCLK=1.
REQ-020 Frame bits 15..12 are leading zeros and ignored; bits 11..0 are the unsigned code C.
REQ-021 Conversion: Uk = sign-extend to N bits of ((C - 2048) shifted left by F-11); full range -1.0 to +2047/2048.
REQ-022 In DONE (1 Clk): Uk loaded with converted value and Bandera_ADC=1 in that same cycle; then IDLE.
REQ-023 Uk SHALL hold its value between DONE cycles; Bandera_ADC is high only in DONE.
REQ-024 Latency from sample tick to Bandera_ADC: 32*SCLK_DIV+2 Clk cycles.
REQ-025 Sample tick in any state other than IDLE: tick ignored, Overrun set to 1 and held until Reset.
REQ-026 Sample tick coinciding with DONE: treated as overrun per REQ-025, no frame started.

Reset
REQ-027 Reset low SHALL immediately force: FSM IDLE, CS_n=1, SCLK=1, Uk=0, Bandera_ADC=0, Overrun=0, sample counter=0, shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no Bandera_ADC pulse; after release the first tick occurs SAMPLE_DIV cycles later.
REQ-029 Reset release is synchronised internally; first state change no earlier than the second Clk edge after release.

Verification (bench params SCLK_DIV=2, SAMPLE_DIV=100, N=25, F=16)
REQ-030 ADC model returns C=0x800 -> Bandera_ADC pulse 66 cycles after tick, Uk=0.
REQ-031 C=0xFFF -> Uk=0x00FFE0 (2047*32); C=0x000 -> Uk=0x1FF0000 (-65536, 25-bit).
REQ-032 Count SCLK during one frame -> exactly 16 rising edges, all with CS_n=0; CS_n low for 65 cycles.
REQ-033 Assert Reset at SCLK edge 8 of a frame -> CS_n=1, SCLK=1, Uk=0 immediately; no Bandera_ADC until the next full frame.
REQ-034 Rebuild with SAMPLE_DIV=40 (< frame) -> Overrun=1 after first frame, remains 1; Bandera_ADC pulses continue on every second tick.
REQ-035 Run 50 consecutive frames with random C -> each Uk matches REQ-021, Bandera_ADC exactly one cycle wide, period 100 cycles.

Source files
------------

// File: rtl/interfaz_adc_spi.sv
// SPI front end for a 12-bit serial ADC: samples at a fixed rate, shifts in one 16-bit frame per sample
// and presents the code as signed fixed point with a one-cycle valid flag for the downstream filter.
module interfaz_adc_spi #(
  parameter int N          = 25,
  parameter int F          = 16,
  parameter int SCLK_DIV   = 4,
  parameter int SAMPLE_DIV = 5000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         SDATA,
  output logic         CS_n,
  output logic         SCLK,
  output logic [N-1:0] Uk,
  output logic         Bandera_ADC,
  output logic         Overrun
);

  localparam int DW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int SW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SHL = F - 11;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [SW-1:0]   smp_cnt;
  logic            tick;
  logic [DW-1:0]   div_cnt, div_nxt;
  logic [4:0]      half_cnt, half_nxt;
  logic            capture;
  logic [15:0]     shreg;
  logic signed [11:0]  code_s;
  logic signed [N-1:0] code_ext;
  logic [N-1:0]    conv;
  logic            unused_lead;

  // Assertion is asynchronous; release is delayed two edges so no flop sees it mid-setup.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign tick = (smp_cnt == SMP_LAST);

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)    smp_cnt <= '0;
    else if (tick) smp_cnt <= '0;
    else           smp_cnt <= smp_cnt + SW'(1);
  end

  // half_cnt indexes the 32 SCLK half-periods; even halves are low, odd halves high.
  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    half_nxt  = half_cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        div_nxt  = '0;
        half_nxt = '0;
        if (tick) state_nxt = SETUP;
      end
      SETUP: state_nxt = SHIFT;
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (half_cnt == 5'd31) begin
            state_nxt = DONE;
          end else begin
            half_nxt = half_cnt + 5'd1;
            capture  = ~half_cnt[0];
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so SCLK and CS_n never glitch.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      half_cnt    <= '0;
      CS_n        <= 1'b1;
      SCLK        <= 1'b1;
      Bandera_ADC <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_nxt;
      half_cnt    <= half_nxt;
      CS_n        <= !(state_nxt == SETUP || state_nxt == SHIFT);
      SCLK        <= (state_nxt == SHIFT) ? half_nxt[0] : 1'b1;
      Bandera_ADC <= (state_nxt == DONE);
    end
  end

  // Offset binary to two's complement is an MSB flip; then scale to F fractional bits.
  assign code_s      = {~shreg[11], shreg[10:0]};
  assign code_ext    = {{(N-12){code_s[11]}}, code_s};
  assign conv        = code_ext <<< SHL;
  assign unused_lead = ^shreg[15:12];

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      Uk      <= '0;
      Overrun <= 1'b0;
    end else begin
      if (capture)                   shreg   <= {shreg[14:0], SDATA};
      if (state_nxt == DONE)         Uk      <= conv;
      if (tick && state != IDLE)     Overrun <= 1'b1;
    end
  end

endmodule
